// File: rtl/intc_sched_pkg.sv
// Shared types and constants for the interrupt scheduler.
// Contents: FSM state enum, source count, default vector constants,
// source id type, in-service payload struct and a one-hot helper.
package intc_pkg;

  localparam int unsigned INTC_NSRC = 4;
  localparam int unsigned INTC_IDW  = 2;

  localparam logic [31:0] INTC_VEC_BASE   = 32'h0000_0000;
  localparam logic [31:0] INTC_VEC_STRIDE = 32'h0000_0004;

  typedef logic [INTC_IDW-1:0] src_id_t;

  typedef enum logic [1:0] {
    INTC_IDLE = 2'd0,
    INTC_REQ  = 2'd1,
    INTC_SERV = 2'd2
  } intc_state_t;

  // {valid, id} of the source currently being serviced
  typedef struct packed {
    logic    valid;
    src_id_t id;
  } svc_t;

  function automatic logic [INTC_NSRC-1:0] src_onehot(input src_id_t id);
    return INTC_NSRC'(1) << id;
  endfunction

endpackage

// File: rtl/intc_sched_if.sv
// Accelerator/CPU side bundle of the interrupt scheduler.
// master: accelerators + CPU (drive done, mask writes, ack, eoi).
// slave : the scheduler (drives irq, PC_handler, acc_reset, in_service, pending).
interface intc_sched_if;
  import intc_pkg::*;

  logic [INTC_NSRC-1:0] done;
  logic                 mask_we;
  logic [INTC_NSRC-1:0] mask_wdata;
  logic                 irq_ack;
  logic                 eoi;
  logic                 irq;
  logic [31:0]          PC_handler;
  logic [INTC_NSRC-1:0] acc_reset;
  logic [2:0]           in_service;
  logic [INTC_NSRC-1:0] pending;

  modport master (
    output done, mask_we, mask_wdata, irq_ack, eoi,
    input  irq, PC_handler, acc_reset, in_service, pending
  );

  modport slave (
    input  done, mask_we, mask_wdata, irq_ack, eoi,
    output irq, PC_handler, acc_reset, in_service, pending
  );

endinterface

// File: rtl/intc_sched_arb.sv
// Combinational arbiter: picks one source out of the eligible vector.
// Ports: elig (eligible sources), ptr (search start), valid/id (grant).
// Macro INTC_RR_EN selects round-robin search from ptr; otherwise the
// lowest index wins and ptr is ignored.
module intc_arb
  import intc_pkg::*;
(
  input  logic [INTC_NSRC-1:0] elig,
  input  src_id_t              ptr,
  output logic                 valid,
  output src_id_t              id
);

`ifdef INTC_RR_EN
  src_id_t idx;

  // Walk from the highest offset down so the smallest offset from ptr wins
  always_comb begin
    valid = 1'b0;
    id    = '0;
    idx   = '0;
    for (int k = INTC_NSRC - 1; k >= 0; k--) begin
      idx = ptr + src_id_t'(k);
      if (elig[idx]) begin
        valid = 1'b1;
        id    = idx;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Walk downward so the lowest index wins
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int k = INTC_NSRC - 1; k >= 0; k--) begin
      if (elig[k]) begin
        valid = 1'b1;
        id    = src_id_t'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/intc_sched.sv
// Interrupt scheduler: edge-captures accelerator done lines into a sticky
// pending register, masks, arbitrates and runs irq/ack/eoi with the CPU,
// pulsing acc_reset to the serviced accelerator on ack.
// Ports: clk, rst (sync, active-high), bus (intc_sched_if.slave).
// Macro INTC_RR_EN enables round-robin arbitration (default: fixed priority).
module intc_sched
  import intc_pkg::*;
#(
  parameter int unsigned N_SRC      = INTC_NSRC,
  parameter logic [31:0] VEC_BASE   = INTC_VEC_BASE,
  parameter logic [31:0] VEC_STRIDE = INTC_VEC_STRIDE
) (
  input  logic         clk,
  input  logic         rst,
  intc_sched_if.slave  bus
);

  intc_state_t      state_q, state_d;
  logic [N_SRC-1:0] done_q, pend_q, pend_d, mask_q, mask_d;
  logic [N_SRC-1:0] rise, elig, clr, acc_q, acc_d;
  src_id_t          gnt_q, gnt_d, ptr, arb_id;
  logic             arb_valid, ack_fire;
  logic             irq_q, irq_d;
  logic [31:0]      pc_q, pc_d;
  svc_t             svc_q, svc_d;

  assign rise     = bus.done & ~done_q;
  assign elig     = pend_q & ~mask_q;
  assign ack_fire = (state_q == INTC_REQ) && bus.irq_ack;

  intc_arb u_arb (
    .elig  (elig),
    .ptr   (ptr),
    .valid (arb_valid),
    .id    (arb_id)
  );

`ifdef INTC_RR_EN
  src_id_t ptr_q;

  // Priority pointer moves just past the source that was serviced
  always_ff @(posedge clk) begin
    if (rst)           ptr_q <= '0;
    else if (ack_fire) ptr_q <= gnt_q + src_id_t'(1);
  end
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INTC_IDLE;
      done_q  <= '0;
      pend_q  <= '0;
      mask_q  <= '1;
      gnt_q   <= '0;
      irq_q   <= 1'b0;
      pc_q    <= '0;
      acc_q   <= '0;
      svc_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= bus.done;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      gnt_q   <= gnt_d;
      irq_q   <= irq_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      svc_q   <= svc_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INTC_IDLE: if (arb_valid)   state_d = INTC_REQ;
      INTC_REQ:  if (bus.irq_ack) state_d = INTC_SERV;
      INTC_SERV: if (bus.eoi)     state_d = INTC_IDLE;
      default:                    state_d = INTC_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    gnt_d  = gnt_q;
    irq_d  = irq_q;
    pc_d   = pc_q;
    svc_d  = svc_q;
    acc_d  = '0;
    clr    = '0;
    mask_d = bus.mask_we ? bus.mask_wdata : mask_q;
    unique case (state_q)
      INTC_IDLE: begin
        if (arb_valid) begin
          gnt_d = arb_id;
          pc_d  = VEC_BASE + 32'(arb_id) * VEC_STRIDE;
          irq_d = 1'b1;
        end
      end
      INTC_REQ: begin
        if (bus.irq_ack) begin
          irq_d = 1'b0;
          acc_d = src_onehot(gnt_q);
          clr   = src_onehot(gnt_q);
          svc_d = '{valid: 1'b1, id: gnt_q};
        end
      end
      INTC_SERV: begin
        if (bus.eoi) svc_d = '0;
      end
      default: ;
    endcase
    // A fresh edge on the cleared source keeps it pending
    pend_d = (pend_q & ~clr) | rise;
  end

  assign bus.irq        = irq_q;
  assign bus.PC_handler = pc_q;
  assign bus.acc_reset  = acc_q;
  assign bus.in_service = svc_q;
  assign bus.pending    = pend_q;

endmodule

// File: tb/tb_intc_sched.sv
// Self-checking bench for intc_sched: directed scenarios against spec
// constants plus a randomized run against a transaction-level model.
module tb_intc_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  intc_sched_if bus ();

  intc_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: request outstanding / in service, chosen source, pointer
  logic [3:0]  m_pend, m_mask, m_prev, m_acc;
  logic        m_irq;
  logic [31:0] m_pc;
  logic [2:0]  m_svc;
  bit          m_req, m_serv;
  int          m_g, m_ptr;

  function automatic void model_edge();
    logic [3:0] rise, elig, clr;
    bit found;
    if (rst) begin
      m_pend = 0; m_mask = 4'hF; m_prev = 0; m_acc = 0; m_irq = 0;
      m_pc = 0; m_svc = 0; m_req = 0; m_serv = 0; m_g = 0; m_ptr = 0;
      return;
    end
    rise  = bus.done & ~m_prev;
    clr   = 0;
    m_acc = 0;
    if (m_req) begin
      if (bus.irq_ack) begin
        m_irq = 0; m_acc = 4'(1 << m_g); clr = m_acc;
        m_svc = {1'b1, 2'(m_g)}; m_req = 0; m_serv = 1;
`ifdef INTC_RR_EN
        m_ptr = (m_g + 1) % 4;
`endif
      end
    end else if (m_serv) begin
      if (bus.eoi) begin m_svc = 0; m_serv = 0; end
    end else begin
      elig  = m_pend & ~m_mask;
      found = 0;
      for (int k = 0; k < 4; k++) begin
        int s;
        s = (m_ptr + k) % 4;
        if (!found && elig[s]) begin found = 1; m_g = s; end
      end
      if (found) begin
        m_pc = 32'(m_g) * 32'd4; m_irq = 1; m_req = 1;
      end
    end
    m_pend = (m_pend & ~clr) | rise;
    if (bus.mask_we) m_mask = bus.mask_wdata;
    m_prev = bus.done;
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mask(input logic [3:0] v);
    bus.mask_we = 1; bus.mask_wdata = v; tick(); bus.mask_we = 0;
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick(); rst = 0;
    n_checks++; if (bus.irq !== 1'b0) $display("FAIL rst_irq got=%0h exp=0", bus.irq); else n_pass++;
    n_checks++; if (bus.PC_handler !== 32'h0) $display("FAIL rst_pc got=%0h exp=0", bus.PC_handler); else n_pass++;
    n_checks++; if (bus.acc_reset !== 4'h0) $display("FAIL rst_acc got=%0h exp=0", bus.acc_reset); else n_pass++;
    n_checks++; if (bus.in_service !== 3'h0) $display("FAIL rst_svc got=%0h exp=0", bus.in_service); else n_pass++;
    n_checks++; if (bus.pending !== 4'h0) $display("FAIL rst_pend got=%0h exp=0", bus.pending); else n_pass++;
    // ack/eoi in IDLE are ignored
    bus.irq_ack = 1; bus.eoi = 1; tick(); tick(); bus.irq_ack = 0; bus.eoi = 0;
    n_checks++; if ({bus.irq, bus.acc_reset, bus.in_service} !== 8'h0)
      $display("FAIL idle_ackeoi got=%0h exp=0", {bus.irq, bus.acc_reset, bus.in_service}); else n_pass++;
  endtask

  task automatic test_single();
    write_mask(4'h0);
    bus.done = 4'b0100; tick();
    n_checks++; if (bus.pending !== 4'b0100 || bus.irq !== 1'b0)
      $display("FAIL single_pend got=%0h/%0h exp=4/0", bus.pending, bus.irq); else n_pass++;
    tick();
    n_checks++; if (bus.irq !== 1'b1 || bus.PC_handler !== 32'h8)
      $display("FAIL single_irq got=%0h/%0h exp=1/8", bus.irq, bus.PC_handler); else n_pass++;
    bus.irq_ack = 1; tick(); bus.irq_ack = 0;
    n_checks++; if (bus.acc_reset !== 4'b0100 || bus.in_service !== 3'b110 || bus.irq !== 1'b0)
      $display("FAIL single_ack got=%0h/%0h/%0h exp=4/6/0", bus.acc_reset, bus.in_service, bus.irq); else n_pass++;
    tick();
    n_checks++; if (bus.acc_reset !== 4'h0 || bus.PC_handler !== 32'h8)
      $display("FAIL single_accpulse got=%0h/%0h exp=0/8", bus.acc_reset, bus.PC_handler); else n_pass++;
    bus.eoi = 1; tick(); bus.eoi = 0;
    n_checks++; if (bus.in_service !== 3'h0) $display("FAIL single_eoi got=%0h exp=0", bus.in_service); else n_pass++;
    bus.done = 0; tick();
  endtask

  task automatic test_two();
    logic [31:0] pc1, pc2;
`ifdef INTC_RR_EN
    pc1 = 32'hC; pc2 = 32'h4;
`else
    pc1 = 32'h4; pc2 = 32'hC;
`endif
    bus.done = 4'b1010; tick(); tick();
    n_checks++; if (bus.irq !== 1'b1 || bus.PC_handler !== pc1)
      $display("FAIL two_first got=%0h/%0h exp=1/%0h", bus.irq, bus.PC_handler, pc1); else n_pass++;
    bus.irq_ack = 1; tick(); bus.irq_ack = 0;
    bus.eoi = 1; tick(); bus.eoi = 0;
    n_checks++; if (bus.irq !== 1'b0) $display("FAIL two_gap got=%0h exp=0", bus.irq); else n_pass++;
    tick();
    n_checks++; if (bus.irq !== 1'b1 || bus.PC_handler !== pc2)
      $display("FAIL two_second got=%0h/%0h exp=1/%0h", bus.irq, bus.PC_handler, pc2); else n_pass++;
    bus.irq_ack = 1; tick(); bus.irq_ack = 0;
    bus.eoi = 1; tick(); bus.eoi = 0;
    bus.done = 0; tick();
  endtask

  task automatic test_mask();
    write_mask(4'b0001);
    bus.done = 4'b0001; tick(); tick(); tick();
    n_checks++; if (bus.pending !== 4'b0001 || bus.irq !== 1'b0)
      $display("FAIL mask_hold got=%0h/%0h exp=1/0", bus.pending, bus.irq); else n_pass++;
    write_mask(4'h0);
    tick();
    n_checks++; if (bus.irq !== 1'b1 || bus.PC_handler !== 32'h0)
      $display("FAIL mask_release got=%0h/%0h exp=1/0", bus.irq, bus.PC_handler); else n_pass++;
    bus.irq_ack = 1; tick(); bus.irq_ack = 0;
    bus.eoi = 1; tick(); bus.eoi = 0;
    bus.done = 0; tick();
  endtask

  task automatic test_ack_rise();
    bus.done = 4'b0001; tick(); tick();
    bus.done = 0; tick();
    bus.done = 4'b0001; bus.irq_ack = 1; tick(); bus.irq_ack = 0;
    n_checks++; if (bus.pending[0] !== 1'b1 || bus.acc_reset !== 4'b0001 || bus.in_service !== 3'b100)
      $display("FAIL ackrise_set got=%0h/%0h/%0h exp=1/1/4", bus.pending, bus.acc_reset, bus.in_service); else n_pass++;
    bus.eoi = 1; tick(); bus.eoi = 0;
    tick();
    n_checks++; if (bus.irq !== 1'b1 || bus.PC_handler !== 32'h0)
      $display("FAIL ackrise_reirq got=%0h/%0h exp=1/0", bus.irq, bus.PC_handler); else n_pass++;
    bus.irq_ack = 1; tick(); bus.irq_ack = 0;
    bus.eoi = 1; tick(); bus.eoi = 0;
    bus.done = 0; tick();
  endtask

  task automatic test_rst_mid();
    bus.done = 4'b0110; tick(); tick();
    n_checks++; if (bus.irq !== 1'b1) $display("FAIL rstmid_pre got=%0h exp=1", bus.irq); else n_pass++;
    bus.done = 0; rst = 1; tick(); rst = 0;
    n_checks++; if ({bus.irq, bus.PC_handler, bus.acc_reset, bus.in_service, bus.pending} !== 44'h0)
      $display("FAIL rstmid_out got=%0h exp=0", {bus.irq, bus.PC_handler, bus.acc_reset, bus.in_service, bus.pending}); else n_pass++;
    tick();
    n_checks++; if (bus.acc_reset !== 4'h0 || bus.irq !== 1'b0)
      $display("FAIL rstmid_after got=%0h/%0h exp=0/0", bus.acc_reset, bus.irq); else n_pass++;
  endtask

  task automatic test_hold();
    int rises;
    logic prev_irq;
    write_mask(4'h0);
    rises = 0; prev_irq = bus.irq;
    bus.done = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      bus.irq_ack = (c == 2); bus.eoi = (c == 3);
      tick();
      if (bus.irq && !prev_irq) rises++;
      prev_irq = bus.irq;
    end
    bus.irq_ack = 0; bus.eoi = 0;
    n_checks++; if (rises !== 1) $display("FAIL hold_irqs got=%0d exp=1", rises); else n_pass++;
    n_checks++; if (bus.pending !== 4'h0 || bus.irq !== 1'b0)
      $display("FAIL hold_pend got=%0h/%0h exp=0/0", bus.pending, bus.irq); else n_pass++;
    bus.done = 0; tick();
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      bus.done       = 4'($urandom);
      bus.mask_we    = ($urandom_range(0, 7) == 0);
      bus.mask_wdata = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      bus.irq_ack    = 1'($urandom_range(0, 1));
      bus.eoi        = 1'($urandom_range(0, 1));
      tick();
      n_checks++;
      if ({bus.irq, bus.PC_handler, bus.acc_reset, bus.in_service, bus.pending} !==
          {m_irq, m_pc, m_acc, m_svc, m_pend}) begin
        if (errs < 10)
          $display("FAIL rand_c%0d got irq=%0h pc=%0h acc=%0h svc=%0h pend=%0h exp irq=%0h pc=%0h acc=%0h svc=%0h pend=%0h",
                   c, bus.irq, bus.PC_handler, bus.acc_reset, bus.in_service, bus.pending,
                   m_irq, m_pc, m_acc, m_svc, m_pend);
        errs++;
      end else n_pass++;
    end
    bus.mask_we = 0; bus.irq_ack = 0; bus.eoi = 0; bus.done = 0;
  endtask

  initial begin
    bus.done = 0; bus.mask_we = 0; bus.mask_wdata = 0; bus.irq_ack = 0; bus.eoi = 0;
    test_reset();
    test_single();
    test_two();
    test_mask();
    test_ack_rise();
    test_rst_mid();
    test_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
